alu_exec: RTL and testbench



---
 rtl/alu_exec_pkg.sv | 19 +
 rtl/alu_exec_if.sv | 30 +++
 rtl/alu_exec_comb.sv | 26 ++
 rtl/alu_exec.sv | 98 +++++++++
 tb/tb_alu_exec.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_exec_pkg.sv
// Shared ALU definitions: op encodings common to the ALU-control decoder and the
// execute stage, default datapath width and the execute FSM state type.
package alu_exec_pkg;

  localparam int unsigned DEFAULT_XLEN = 32;

  localparam logic [2:0] ALU_SUB = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;

  typedef enum logic {
    IDLE,
    SHIFT
  } alu_state_e;

endpackage

// File: rtl/alu_exec_if.sv
// Operand/result handshake bundle of the execute-stage ALU.
// master = upstream producer / result consumer side, slave = alu_exec.
interface alu_exec_if
  import alu_exec_pkg::*;
#(
  parameter int unsigned XLEN = DEFAULT_XLEN
);

  logic            in_valid;
  logic            in_ready;
  logic [2:0]      alu_ctrl;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            busy;

  modport master (
    output in_valid, alu_ctrl, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, alu_ctrl, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, busy
  );

endinterface

// File: rtl/alu_exec_comb.sv
// Combinational single-cycle ALU ops; SLL and the reserved codes yield zero here
// and are resolved by alu_exec.
module alu_comb
  import alu_exec_pkg::*;
#(
  parameter int unsigned XLEN = DEFAULT_XLEN
) (
  input  logic [2:0]      alu_ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  always_comb begin
    y = '0;
    case (alu_ctrl)
      ALU_SUB: y = a - b;
      ALU_ADD: y = a + b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: valid/ready handshake, registered result/zero, and an
// iterative one-bit-per-cycle SLL that stalls the stage while shifting.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int unsigned XLEN = DEFAULT_XLEN,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input logic     clk,
  input logic     rst,
  alu_exec_if.slave bus
);

  localparam logic [SHW-1:0] CNT_LAST = SHW'(1);

  alu_state_e      state, state_n;
  logic [XLEN-1:0] acc, acc_n;
  logic [SHW-1:0]  cnt, cnt_n;
  logic [XLEN-1:0] result_q, result_n;
  logic            zero_q, zero_n;
  logic            out_valid_q, out_valid_n;

  logic [XLEN-1:0] comb_y;
  logic [SHW-1:0]  shamt;
  logic            accept;

  alu_comb #(.XLEN(XLEN)) u_comb (
    .alu_ctrl (bus.alu_ctrl),
    .a        (bus.op_a),
    .b        (bus.op_b),
    .y        (comb_y)
  );

  assign shamt         = bus.op_b[SHW-1:0];
  assign bus.in_ready  = (state == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.busy      = (state == SHIFT);

  always_comb begin
    state_n     = state;
    acc_n       = acc;
    cnt_n       = cnt;
    result_n    = result_q;
    zero_n      = zero_q;
    out_valid_n = out_valid_q;
    if (out_valid_q && bus.out_ready) out_valid_n = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.alu_ctrl == ALU_SLL && shamt != '0) begin
            acc_n   = bus.op_a;
            cnt_n   = shamt;
            state_n = SHIFT;
          end else begin
            // SLL by zero bypasses the shifter and completes like a 1-cycle op
            result_n    = (bus.alu_ctrl == ALU_SLL) ? bus.op_a : comb_y;
            zero_n      = (result_n == '0);
            out_valid_n = 1'b1;
          end
        end
      end
      SHIFT: begin
        acc_n = acc << 1;
        cnt_n = cnt - CNT_LAST;
        if (cnt == CNT_LAST) begin
          result_n    = acc << 1;
          zero_n      = (result_n == '0);
          out_valid_n = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_n;
      acc         <= acc_n;
      cnt         <= cnt_n;
      result_q    <= result_n;
      zero_q      <= zero_n;
      out_valid_q <= out_valid_n;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed vector table, hand-written handshake
// and reset sequences, then randomized ops against a behavioural reference.
module tb_alu_exec;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_exec_if #(.XLEN(32)) bus ();

  alu_exec #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: op semantics from the encoding table, plain arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (c)
      3'd0:    return a - b;
      3'd1:    return a + b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a << sh;
      3'd6:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] c, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    return (c == 3'd4 && sh != 0) ? int'(sh) + 1 : 1;
  endfunction

  // Present a bundle at the negedge, hold until accepted; returns #1 after the accept edge.
  task automatic send(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.alu_ctrl = c;
    bus.op_a     = a;
    bus.op_b     = b;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output logic [31:0] res, output logic z, output int lat, output int busy_cyc);
    lat = 1;
    busy_cyc = 0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.busy && !bus.in_ready) busy_cyc++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= 100) check("result_timeout", 32'(lat), 32'd0);
    res = bus.result;
    z   = bus.zero;
  endtask

  task automatic run_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input int el);
    logic [31:0] res;
    logic        z;
    int          lat, bc;
    send(c, a, b);
    wait_result(res, z, lat, bc);
    check("result", res, er);
    check("zero", {31'b0, z}, {31'b0, (er == 32'd0)});
    check("latency", 32'(lat), 32'(el));
    check("busy_cycles", 32'(bc), 32'(el - 1));
  endtask

  initial begin
    logic [31:0] res, held;
    logic        z;
    int          lat, bc;

    vecs[0]  = '{3'b001, 32'd5,          32'd7,          32'd12,         1};
    vecs[1]  = '{3'b000, 32'd3,          32'd3,          32'd0,          1};
    vecs[2]  = '{3'b110, 32'hFFFF_FFFF,  32'd1,          32'd1,          1};
    vecs[3]  = '{3'b110, 32'd1,          32'hFFFF_FFFF,  32'd0,          1};
    vecs[4]  = '{3'b010, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1};
    vecs[5]  = '{3'b011, 32'h0F0F_0000,  32'h0000_00F0,  32'h0F0F_00F0,  1};
    vecs[6]  = '{3'b100, 32'd1,          32'd4,          32'h10,         5};
    vecs[7]  = '{3'b100, 32'h1234,       32'd0,          32'h1234,       1};
    vecs[8]  = '{3'b100, 32'h8000_0001,  32'd31,         32'h8000_0000,  32};
    vecs[9]  = '{3'b100, 32'h8000_0001,  32'd32,         32'h8000_0001,  1};
    vecs[10] = '{3'b101, 32'd5,          32'd6,          32'd0,          1};
    vecs[11] = '{3'b111, 32'd9,          32'd9,          32'd0,          1};
    vecs[12] = '{3'b001, 32'hFFFF_FFFF,  32'd1,          32'd0,          1};
    vecs[13] = '{3'b000, 32'd0,          32'd1,          32'hFFFF_FFFF,  1};
    vecs[14] = '{3'b100, 32'd3,          32'hFFFF_FFE1,  32'd6,          2};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.alu_ctrl  = 3'b000;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_zero", {31'b0, bus.zero}, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

    for (int i = 0; i < 15; i++)
      run_op(vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].lat);

    @(posedge clk);
    #1;
    check("drain_out_valid", {31'b0, bus.out_valid}, 32'd0);

    // Back-to-back SUB then SLT with no bubble
    send(3'b000, 32'd3, 32'd3);
    check("b2b_sub_valid", {31'b0, bus.out_valid}, 32'd1);
    check("b2b_sub_result", bus.result, 32'd0);
    check("b2b_sub_zero", {31'b0, bus.zero}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.alu_ctrl = 3'b110;
    bus.op_a     = 32'hFFFF_FFFF;
    bus.op_b     = 32'd1;
    check("b2b_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("b2b_slt_valid", {31'b0, bus.out_valid}, 32'd1);
    check("b2b_slt_result", bus.result, 32'd1);
    check("b2b_slt_zero", {31'b0, bus.zero}, 32'd0);

    // Output hold under backpressure, then drain and accept on one edge
    send(3'b001, 32'd10, 32'd20);
    bus.out_ready = 1'b0;
    check("hold_first", bus.result, 32'd30);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.alu_ctrl = 3'b001;
    bus.op_a     = 32'd1;
    bus.op_b     = 32'd2;
    for (int i = 0; i < 3; i++) begin
      check("hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
      check("hold_valid", {31'b0, bus.out_valid}, 32'd1);
      check("hold_result", bus.result, 32'd30);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    check("release_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("release_valid", {31'b0, bus.out_valid}, 32'd1);
    check("release_result", bus.result, 32'd3);

    // in_valid and operand changes during a shift are ignored
    send(3'b100, 32'd3, 32'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.alu_ctrl = 3'b001;
      bus.op_a     = 32'hDEAD_BEEF;
      bus.op_b     = 32'd2;
      #1;
      check("shift_in_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    wait_result(res, z, lat, bc);
    check("shift_isolated_result", res, 32'd96);

    // Reset mid-shift aborts the in-flight SLL
    send(3'b100, 32'd1, 32'd10);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("abort_result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(3'b001, 32'd1, 32'd1, 32'd2, 1);
    run_op(3'b101, 32'd7, 32'd8, 32'd0, 1);

    // Randomized ops with occasional backpressure
    for (int i = 0; i < 200; i++) begin
      logic [2:0]  c;
      logic [31:0] a, b;
      c = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'd0;
      if (c == 3'd6 && $urandom_range(0, 3) == 0) b = a;
      run_op(c, a, b, ref_res(c, a, b), ref_lat(c, b));
      if ($urandom_range(0, 3) == 0) begin
        held = ref_res(c, a, b);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
          @(posedge clk);
          #1;
          check("rand_hold_valid", {31'b0, bus.out_valid}, 32'd1);
          check("rand_hold_result", bus.result, held);
        end
        bus.out_ready = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
